// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// The divider datapath is only built when MULDIV_DIV_EN is defined.
package muldiv_pkg;

  localparam int ITER  = 32;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_WRITE = 2'b10
  } state_e;

  function automatic logic op_is_div(input op_e o);
    return o[1];
  endfunction

  function automatic logic op_is_signed(input op_e o);
    return ~o[0];
  endfunction

  // Magnitude of a two's-complement value; 32'h8000_0000 maps onto itself as unsigned.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One-bit-per-cycle datapath: radix-2 shift-add multiply and restoring divide.
// The divide path (and its select input) exists only with MULDIV_DIV_EN defined.
module muldiv_iter
  import muldiv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        step_i,
`ifdef MULDIV_DIV_EN
  input  logic        div_i,
`endif
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] b_q, b_d;
  logic [32:0] sum;
`ifdef MULDIV_DIV_EN
  logic        div_q, div_d;
  logic [32:0] shifted;
`endif

  // HI holds the running partial product / remainder, LO the multiplier / quotient bits.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    b_d  = b_q;
    sum  = '0;
`ifdef MULDIV_DIV_EN
    div_d   = div_q;
    shifted = {hi_q, lo_q[31]};
`endif
    if (load_i) begin
      hi_d = '0;
      lo_d = a_i;
      b_d  = b_i;
`ifdef MULDIV_DIV_EN
      div_d = div_i;
`endif
    end else if (step_i) begin
`ifdef MULDIV_DIV_EN
      if (div_q) begin
        if (shifted >= {1'b0, b_q}) begin
          hi_d = shifted[31:0] - b_q;
          lo_d = {lo_q[30:0], 1'b1};
        end else begin
          hi_d = shifted[31:0];
          lo_d = {lo_q[30:0], 1'b0};
        end
      end else begin
`endif
        sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : 33'd0);
        hi_d = sum[32:1];
        lo_d = {sum[0], lo_q[31:1]};
`ifdef MULDIV_DIV_EN
      end
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_q <= '0;
      lo_q <= '0;
      b_q  <= '0;
`ifdef MULDIV_DIV_EN
      div_q <= 1'b0;
`endif
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      b_q  <= b_d;
`ifdef MULDIV_DIV_EN
      div_q <= div_d;
`endif
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit writing HI/LO 33 cycles after start.
// Divide ops are accepted only when MULDIV_DIV_EN is defined.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        done,
  output logic        hi_w,
  output logic [31:0] hi_wdata,
  output logic        lo_w,
  output logic [31:0] lo_wdata
);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               fin_q;
  op_e                op_q;
  logic [31:0]        srcA_q;
  logic               bNeg_q;
  logic               bZero_q;
  logic               busy_q;
  logic               done_q;
  logic [31:0]        hiData_q;
  logic [31:0]        loData_q;

  logic               accept;
  logic               inSigned;
  logic [31:0]        iterHi;
  logic [31:0]        iterLo;
  logic [63:0]        prod;
  logic               negRes;
  logic [31:0]        hiRes_d;
  logic [31:0]        loRes_d;

  assign inSigned = op_is_signed(op_e'(op));
`ifdef MULDIV_DIV_EN
  assign accept = start;
`else
  assign accept = start && !op_is_div(op_e'(op));
`endif

  muldiv_iter u_iter (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .load_i (state_q == ST_IDLE && accept),
    .step_i (state_q == ST_RUN && !fin_q),
`ifdef MULDIV_DIV_EN
    .div_i  (op[1]),
`endif
    .a_i    (mag32(src_a, inSigned)),
    .b_i    (mag32(src_b, inSigned)),
    .hi_o   (iterHi),
    .lo_o   (iterLo)
  );

  // Divide by zero bypasses sign fix-up so HI returns the raw dividend.
  always_comb begin
    prod    = {iterHi, iterLo};
    negRes  = op_is_signed(op_q) && (srcA_q[31] ^ bNeg_q);
    hiRes_d = iterHi;
    loRes_d = iterLo;
    if (!op_is_div(op_q)) begin
      if (negRes) {hiRes_d, loRes_d} = ~prod + 64'd1;
    end else if (bZero_q) begin
      hiRes_d = srcA_q;
      loRes_d = '1;
    end else begin
      if (negRes) loRes_d = ~iterLo + 32'd1;
      if (op_is_signed(op_q) && srcA_q[31]) hiRes_d = ~iterHi + 32'd1;
    end
  end

  // fin_q adds the cycle that registers the sign-corrected result after 32 steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      fin_q    <= 1'b0;
      op_q     <= OP_MULT;
      srcA_q   <= '0;
      bNeg_q   <= 1'b0;
      bZero_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hiData_q <= '0;
      loData_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            fin_q   <= 1'b0;
            op_q    <= op_e'(op);
            srcA_q  <= src_a;
            bNeg_q  <= src_b[31];
            bZero_q <= (src_b == 32'd0);
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (fin_q) begin
            state_q  <= ST_WRITE;
            fin_q    <= 1'b0;
            done_q   <= 1'b1;
            hiData_q <= hiRes_d;
            loData_q <= loRes_d;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(ITER - 1)) fin_q <= 1'b1;
          end
        end
        ST_WRITE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign hi_w     = done_q;
  assign lo_w     = done_q;
  assign hi_wdata = hiData_q;
  assign lo_wdata = loData_q;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-004 SHALL have port op, input, 2 bits: operation select, 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have port src_a, input, 32 bits: multiplicand or dividend.
REQ-006 SHALL have port src_b, input, 32 bits: multiplier or divisor.
REQ-007 SHALL have port busy, output, 1 bit: high while an operation is in flight.
REQ-008 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have port hi_w, output, 1 bit: HI register write enable.
REQ-010 SHALL have port hi_wdata, output, 32 bits: HI write data.
REQ-011 SHALL have port lo_w, output, 1 bit: LO register write enable.
REQ-012 SHALL have port lo_wdata, output, 32 bits: LO write data.

Function
REQ-013 SHALL implement FSM states IDLE -> RUN -> WRITE -> IDLE.
REQ-014 SHALL move IDLE -> RUN when start=1 at a rising edge, latching op, src_a and src_b; no other transition leaves IDLE.
REQ-015 SHALL run RUN for exactly 32 cycles (5-bit counter, 0..31); multiply is radix-2 shift-add, divide is restoring, one bit per cycle.
REQ-016 SHALL treat signed ops (MULT, DIV) as magnitudes, then apply sign correction in WRITE: product sign = sign(a) XOR sign(b); quotient sign likewise; remainder sign follows the dividend.
REQ-017 SHALL, in WRITE (one cycle), assert hi_w, lo_w and done together, and drive registered data on hi_wdata and lo_wdata. Multiply: HI = product[63:32], LO = product[31:0]. Divide: HI = remainder, LO = quotient.
REQ-018 SHALL make start-to-write latency fixed at 33 cycles: start sampled at edge N, write asserted during the cycle after edge N+33.
REQ-019 SHALL hold hi_w, lo_w and data stable for the full WRITE cycle, so that a HI/LO store capturing on the falling edge samples valid values.
REQ-020 SHALL keep busy=1 in RUN and WRITE, and busy=0 in IDLE.
REQ-021 SHALL ignore start while busy; operands are not re-latched.
REQ-022 SHALL, on divide by zero, still take 33 cycles, then write LO = 32'hFFFF_FFFF and HI = src_a.
REQ-023 SHALL, for DIV 32'h8000_0000 / 32'hFFFF_FFFF, write LO = 32'h8000_0000 and HI = 0.
REQ-024 SHALL keep hi_w, lo_w and done at 0 in every state except WRITE.

Reset
REQ-025 SHALL, on rst_n=0 and at any time including mid-RUN, force IDLE, counter 0, busy=0, done=0, hi_w=0, lo_w=0, hi_wdata=0 and lo_wdata=0; an in-flight operation is discarded with no write.
REQ-026 SHALL return to normal start sampling at the first rising edge after rst_n deasserts.

Configuration
REQ-027 SHALL, with MULDIV_DIV_EN defined, support all four ops as specified.
REQ-028 SHALL, without MULDIV_DIV_EN, exclude the divider datapath; start with op=DIV or DIVU is ignored (stays IDLE, busy=0, no write).

Structure
REQ-029 SHALL place the op encodings, the FSM state type and the ITER=32 constant in shared package muldiv_pkg.
REQ-030 SHALL place the iterative shift/add-subtract datapath in one sub-module muldiv_iter; muldiv_unit holds the FSM, sign handling and write port.

Verification
REQ-031 SHALL cover: MULTU a=32'hFFFF_FFFF, b=2 -> after 33 cycles, one-cycle hi_w/lo_w, HI=1, LO=32'hFFFF_FFFE.
REQ-032 SHALL cover: MULT a=-3, b=5 -> HI=32'hFFFF_FFFF, LO=32'hFFFF_FFF1, done pulse exactly 1 cycle.
REQ-033 SHALL cover: DIV a=-7, b=2 -> LO=32'hFFFF_FFFD (-3), HI=32'hFFFF_FFFF (-1); DIVU 7/0 -> LO=32'hFFFF_FFFF, HI=7.
REQ-034 SHALL cover: start reasserted with new operands at cycle 10 of a run -> ignored; the original result is written at cycle 33.
REQ-035 SHALL cover: rst_n pulsed low at cycle 20 of a run -> busy=0 immediately, no hi_w/lo_w; a fresh MULTU 3*4 then writes LO=12, HI=0.
REQ-036 SHALL cover: build without MULDIV_DIV_EN, DIV start -> busy stays 0 and no write occurs.
